p2_master: RTL and testbench

P2_MASTER -- requirements
Module: p2_master

---
 rtl/p2_pkg.sv | 15 +
 rtl/p2_timer.sv | 32 +++
 rtl/p2_master.sv | 157 +++++++++++++++
 tb/tb_p2_master.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/p2_pkg.sv
// Shared P2 bus definitions: bus widths, the default timeout and the master state encoding.
// The slave blocks use the same package.
package p2_pkg;
    localparam int P2_AW          = 23;
    localparam int P2_DW          = 16;
    localparam int P2_TIMEOUT_DEF = 255;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR   = 3'd1,
        ST_STROBE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } p2_state_t;
endpackage

// File: rtl/p2_timer.sv
// Bus-cycle timeout: a down-counter loaded with TIMEOUT that counts the STROBE and WAIT cycles.
// expire fires on the TIMEOUT-th enabled cycle.
module p2_timer
    import p2_pkg::*;
#(
    parameter int TIMEOUT = P2_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    logic [7:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= 8'(TIMEOUT);
        end else if (i_en) begin
            if (r_count != 8'd0) r_count <= r_count - 8'd1;
        end else begin
            r_count <= '0;
        end
    end

    // The count equals TIMEOUT in STROBE, so a count of 1 marks strobe cycle number TIMEOUT.
    assign o_expire = i_en && (r_count == 8'd1);

endmodule

// File: rtl/p2_master.sv
// P2 bus master: turns a single host request into one ADDR/STROBE/WAIT/DONE bus cycle.
// All bus strobes come straight from flops, which keeps them free of glitches.
//
// state  | meaning
// IDLE   | waiting for req; bus strobes released, addr holds the last address
// ADDR   | address valid, ras_n low
// STROBE | cas_n/go_n low, write strobes and datai driven; wait_n ignored
// WAIT   | strobes held until wait_n is high or the timeout expires
// DONE   | strobes released, ack pulsed with err
module p2_master
    import p2_pkg::*;
#(
    parameter int TIMEOUT = P2_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req,
    input  logic [P2_AW-1:0] req_addr,
    input  logic             req_write,
    input  logic [1:0]       req_be,
    input  logic [P2_DW-1:0] req_wdata,
    output logic             busy,
    output logic             ack,
    output logic             err,
    output logic [P2_DW-1:0] rdata,
    output logic [P2_AW-1:0] addr,
    output logic             ras_n,
    output logic             cas_n,
    output logic             wel_n,
    output logic             weu_n,
    output logic             rw_n,
    output logic             go_n,
    input  logic             wait_n,
    output logic [P2_DW-1:0] datai,
    input  logic [P2_DW-1:0] datao
);

    p2_state_t        r_state;
    p2_state_t        w_state_nxt;
    logic [P2_AW-1:0] r_addr;
    logic             r_write;
    logic [1:0]       r_be;
    logic [P2_DW-1:0] r_wdata;
    logic             r_busy, r_ack, r_err;
    logic [P2_DW-1:0] r_rdata;
    logic             r_ras_n, r_cas_n, r_go_n, r_wel_n, r_weu_n, r_rw_n;
    logic [P2_DW-1:0] r_datai;

    logic             w_accept, w_done_ok, w_done_to;
    logic             w_active, w_strb;
    logic             w_write;
    logic [1:0]       w_be;
    logic [P2_DW-1:0] w_wdata;
    logic             w_expire;

    p2_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_load   (r_state == ST_ADDR),
        .i_en     ((r_state == ST_STROBE) || (r_state == ST_WAIT)),
        .o_expire (w_expire)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done_ok   = 1'b0;
        w_done_to   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_ADDR:   w_state_nxt = ST_STROBE;
            ST_STROBE: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                // A release in the timeout cycle wins over the timeout.
                if (wait_n) begin
                    w_done_ok   = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (w_expire) begin
                    w_done_to   = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase

        w_active = (w_state_nxt == ST_ADDR) || (w_state_nxt == ST_STROBE) || (w_state_nxt == ST_WAIT);
        w_strb   = (w_state_nxt == ST_STROBE) || (w_state_nxt == ST_WAIT);
        // The ADDR outputs are launched on the accept edge, before the request registers update.
        w_write  = w_accept ? req_write : r_write;
        w_be     = w_accept ? req_be    : r_be;
        w_wdata  = w_accept ? req_wdata : r_wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_write <= 1'b0;
            r_be    <= '0;
            r_wdata <= '0;
            r_busy  <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_ras_n <= 1'b1;
            r_cas_n <= 1'b1;
            r_go_n  <= 1'b1;
            r_wel_n <= 1'b1;
            r_weu_n <= 1'b1;
            r_rw_n  <= 1'b1;
            r_datai <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr  <= req_addr;
                r_write <= req_write;
                r_be    <= req_be;
                r_wdata <= req_wdata;
            end
            r_busy  <= w_active;
            r_ack   <= (w_state_nxt == ST_DONE);
            r_err   <= w_done_to;
            r_ras_n <= !w_active;
            r_cas_n <= !w_strb;
            r_go_n  <= !w_strb;
            r_wel_n <= !(w_strb && w_write && w_be[0]);
            r_weu_n <= !(w_strb && w_write && w_be[1]);
            r_rw_n  <= !(w_active && w_write);
            r_datai <= (w_strb && w_write) ? w_wdata : '0;
            if (w_done_ok && !r_write) begin
                r_rdata <= datao;
            end else if (w_done_to && !r_write) begin
                r_rdata <= 16'hFFFF;
            end
        end
    end

    assign busy  = r_busy;
    assign ack   = r_ack;
    assign err   = r_err;
    assign rdata = r_rdata;
    assign addr  = r_addr;
    assign ras_n = r_ras_n;
    assign cas_n = r_cas_n;
    assign go_n  = r_go_n;
    assign wel_n = r_wel_n;
    assign weu_n = r_weu_n;
    assign rw_n  = r_rw_n;
    assign datai = r_datai;

endmodule

// File: tb/tb_p2_master.sv
// Bench for p2_master: an open-loop driver plays host and slave and queues the expected result of
// each cycle; a monitor checks ack timing, err, rdata and the strobe pattern against that queue.
`timescale 1ns/1ps
module tb_p2_master;
    import p2_pkg::*;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req = 1'b0;
    logic [22:0] req_addr = '0;
    logic        req_write = 1'b0;
    logic [1:0]  req_be = '0;
    logic [15:0] req_wdata = '0;
    logic        busy, ack, err;
    logic [15:0] rdata;
    logic [22:0] addr;
    logic        ras_n, cas_n, wel_n, weu_n, rw_n, go_n;
    logic        wait_n = 1'b1;
    logic [15:0] datai;
    logic [15:0] datao = '0;

    p2_master #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr), .req_write(req_write),
        .req_be(req_be), .req_wdata(req_wdata), .busy(busy), .ack(ack), .err(err), .rdata(rdata),
        .addr(addr), .ras_n(ras_n), .cas_n(cas_n), .wel_n(wel_n), .weu_n(weu_n), .rw_n(rw_n),
        .go_n(go_n), .wait_n(wait_n), .datai(datai), .datao(datao)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [22:0] a;
        logic        w;
        logic [1:0]  be;
        logic [15:0] wd;
        logic [15:0] rd;
        logic        er;
        int          n;
        int          ack_cyc;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] m_rdata = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: counts strobe/busy lengths per bus cycle and checks each ack against the queue head.
    int   n_go = 0, n_busy = 0, n_ras = 0;
    bit   sig_bad = 1'b0;
    logic [15:0] hold_rd = '0;
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            n_go = 0; n_busy = 0; n_ras = 0; sig_bad = 1'b0; hold_rd = '0;
        end else begin
            if (!go_n) begin
                n_go++;
                if (q.size() > 0) begin
                    e = q[0];
                    if ({addr, rw_n, wel_n, weu_n, datai} !==
                        {e.a, !e.w, !(e.w && e.be[0]), !(e.w && e.be[1]), (e.w ? e.wd : 16'h0000)})
                        sig_bad = 1'b1;
                end else begin
                    sig_bad = 1'b1;
                end
            end
            if (busy) n_busy++;
            if (!ras_n) n_ras++;
            if (ack) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_ack: got ack with nothing outstanding (cycle %0d)", cyc);
                end else begin
                    e = q.pop_front();
                    chk("ack_cycle", cyc, e.ack_cyc);
                    chk("err", {31'd0, err}, {31'd0, e.er});
                    chk("rdata", {16'd0, rdata}, {16'd0, e.rd});
                    chk("go_len", n_go, e.n);
                    chk("busy_len", n_busy, e.n + 1);
                    chk("ras_len", n_ras, e.n + 1);
                    chk("strobe_sigs", {31'd0, sig_bad}, 32'd0);
                    chk("done_strobes", {25'd0, busy, ras_n, cas_n, go_n, wel_n, weu_n, rw_n}, 32'h3f);
                    hold_rd = e.rd;
                end
                n_go = 0; n_busy = 0; n_ras = 0; sig_bad = 1'b0;
            end else begin
                chk("rdata_hold", {16'd0, rdata}, {16'd0, hold_rd});
                if (q.size() > 0 && cyc > q[0].ack_cyc) begin
                    total++; bad++;
                    $display("FAIL ack_missing: no ack by cycle %0d expected %0d", cyc, q[0].ack_cyc);
                    void'(q.pop_front());
                    n_go = 0; n_busy = 0; n_ras = 0; sig_bad = 1'b0;
                end
            end
        end
    end

    // One bus cycle. L = number of cycles from STROBE with wait_n low. vary makes datao change
    // every cycle so the capture cycle matters. abort_k > 0 stops (unqueued) inside cycle abort_k.
    task automatic run_txn(input logic [22:0] a, input logic w, input logic [1:0] be,
                           input logic [15:0] wd, input logic [15:0] d, input bit vary,
                           input int L, input bit hold, input int abort_k);
        exp_t e;
        int   c, n, kend;
        c = (L + 1 < 2) ? 2 : L + 1;
        if (c <= TO) begin
            n = c; e.er = 1'b0;
            e.rd = w ? m_rdata : (vary ? (d ^ 16'(c + 1)) : d);
        end else begin
            n = TO; e.er = 1'b1;
            e.rd = w ? m_rdata : 16'hFFFF;
        end
        e.a = a; e.w = w; e.be = be; e.wd = wd; e.n = n;
        req = 1'b1; req_addr = a; req_write = w; req_be = be; req_wdata = wd;
        @(posedge clk); #1;
        e.ack_cyc = cyc + n + 1;
        if (abort_k == 0) begin
            q.push_back(e);
            m_rdata = e.rd;
        end
        req = hold;
        req_addr = 23'($urandom); req_write = 1'($urandom); req_be = 2'($urandom);
        req_wdata = 16'($urandom);
        kend = (abort_k > 0) ? abort_k : n + 2;
        for (int k = 1; k <= kend; k++) begin
            wait_n = !(k >= 2 && k <= L + 1);
            datao  = vary ? (d ^ 16'(k)) : d;
            if (k == abort_k) break;
            @(posedge clk); #1;
        end
        if (abort_k == 0) wait_n = 1'b1;
    endtask

    initial begin
        #12;
        chk("rst_strobes", {26'd0, ras_n, cas_n, go_n, wel_n, weu_n, rw_n}, 32'h3f);
        chk("rst_flags", {29'd0, busy, ack, err}, 32'd0);
        chk("rst_addr", {9'd0, addr}, 32'd0);
        chk("rst_data", {datai, rdata}, 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;

        run_txn(23'h000100, 1'b0, 2'b11, 16'h0000, 16'hBEEF, 1'b0, 0, 1'b0, 0);
        run_txn(23'h700010, 1'b1, 2'b01, 16'h1234, 16'h0000, 1'b0, 0, 1'b0, 0);
        run_txn(23'h780000, 1'b0, 2'b11, 16'h0000, 16'hA5C3, 1'b1, 5, 1'b0, 0);
        run_txn(23'h500000, 1'b0, 2'b11, 16'h0000, 16'h1357, 1'b1, 1000, 1'b0, 0);
        run_txn(23'h500002, 1'b1, 2'b10, 16'hCAFE, 16'h0000, 1'b0, 1000, 1'b0, 0);
        run_txn(23'h012345, 1'b0, 2'b11, 16'h0000, 16'h6B6B, 1'b1, TO - 1, 1'b0, 0);
        run_txn(23'h0ABCDE, 1'b1, 2'b00, 16'hFFFF, 16'h0000, 1'b0, 2, 1'b0, 0);
        repeat (2) begin @(posedge clk); #1; end
        run_txn(23'h111111, 1'b0, 2'b11, 16'h0000, 16'h2222, 1'b0, 0, 1'b1, 0);
        run_txn(23'h333333, 1'b1, 2'b11, 16'h4444, 16'h0000, 1'b0, 0, 1'b0, 0);

        run_txn(23'h123456, 1'b0, 2'b11, 16'h0000, 16'h5555, 1'b0, 50, 1'b0, 4);
        #1 reset_n = 1'b0;
        #1;
        chk("abort_strobes", {26'd0, ras_n, cas_n, go_n, wel_n, weu_n, rw_n}, 32'h3f);
        chk("abort_flags", {29'd0, busy, ack, err}, 32'd0);
        chk("abort_addr", {9'd0, addr}, 32'd0);
        m_rdata = '0;
        req = 1'b0; wait_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        run_txn(23'h654321, 1'b0, 2'b11, 16'h0000, 16'h9A9A, 1'b1, 3, 1'b0, 0);

        for (int i = 0; i < 30; i++) begin
            run_txn(23'($urandom), 1'($urandom), 2'($urandom), 16'($urandom), 16'($urandom),
                    1'b1, int'($urandom_range(0, 10)), 1'b0, 0);
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        repeat (4) begin @(posedge clk); #1; end
        chk("queue_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
